// File: rtl/board_pkg.sv
// Shared board geometry, scanner state encoding and cell indexing for the
// Game of Life display path.
package board_pkg;

  localparam int BOARD_ROWS = 16;
  localparam int BOARD_COLS = 16;
  localparam int BOARD_BITS = 256;

  localparam logic [5:0] ST_IDLE    = 6'b000001;
  localparam logic [5:0] ST_LOAD    = 6'b000010;
  localparam logic [5:0] ST_SHIFT   = 6'b000100;
  localparam logic [5:0] ST_BLANK   = 6'b001000;
  localparam logic [5:0] ST_LATCH   = 6'b010000;
  localparam logic [5:0] ST_DISPLAY = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE    = ST_IDLE,
    S_LOAD    = ST_LOAD,
    S_SHIFT   = ST_SHIFT,
    S_BLANK   = ST_BLANK,
    S_LATCH   = ST_LATCH,
    S_DISPLAY = ST_DISPLAY
  } scan_state_e;

  // Cell (r, c) lives at bit 16*r + c, which is simply {r, c}.
  function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/board_matrix_scanner_row_shift_out.sv
// Serialises one 16-cell row to 74HC595-style column registers, column 15
// first, with sr_clk low for SHIFT_DIV cycles then high for SHIFT_DIV cycles.
module row_shift_out #(
  parameter int SHIFT_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [15:0] row_i,
  output logic        sr_data_o,
  output logic        sr_clk_o,
  output logic        done_o
);

  localparam int DIV_W = $clog2(SHIFT_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

  logic [15:0]      sreg_q;
  logic [3:0]       bit_q;
  logic [DIV_W-1:0] div_q;
  logic             busy_q;
  logic             data_q;
  logic             sclk_q;

  // Combinational so the scanner leaves SHIFT on the very edge that ends bit 15.
  assign done_o    = busy_q && (div_q == DIV_LAST) && sclk_q && (bit_q == 4'd15);
  assign sr_data_o = data_q;
  assign sr_clk_o  = sclk_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_q <= '0;
      bit_q  <= '0;
      div_q  <= '0;
      busy_q <= 1'b0;
      data_q <= 1'b0;
      sclk_q <= 1'b0;
    end else if (start_i) begin
      sreg_q <= {row_i[14:0], 1'b0};
      data_q <= row_i[15];
      sclk_q <= 1'b0;
      bit_q  <= '0;
      div_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          // Data moves only together with the falling shift clock.
          sclk_q <= 1'b0;
          if (bit_q == 4'd15) begin
            busy_q <= 1'b0;
            data_q <= 1'b0;
          end else begin
            bit_q  <= bit_q + 4'd1;
            data_q <= sreg_q[15];
            sreg_q <= {sreg_q[14:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_matrix_scanner.sv
// Snapshots the 256-cell board once per frame and scans it row by row onto a
// 16x16 LED matrix through serial column registers and a 4-bit row select.
module board_matrix_scanner
  import board_pkg::*;
#(
  parameter int SHIFT_DIV    = 4,
  parameter int DWELL_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [BOARD_BITS-1:0] board_i,
  output logic                  sr_data_o,
  output logic                  sr_clk_o,
  output logic                  sr_latch_o,
  output logic [3:0]            row_sel_o,
  output logic                  row_en_o,
  output logic                  frame_o,
  output logic [5:0]            dbg_state_o
);

  localparam int DIV_W   = $clog2(SHIFT_DIV) + 1;
  localparam int DWELL_W = $clog2(DWELL_CYCLES) + 1;
  localparam logic [DIV_W-1:0]   LAT_LAST   = DIV_W'(SHIFT_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  scan_state_e           state_q;
  logic [BOARD_BITS-1:0] snap_q;
  logic [3:0]            row_q;
  logic [DWELL_W-1:0]    dwell_q;
  logic [DIV_W-1:0]      lat_q;
  logic                  latch_q;
  logic [3:0]            row_sel_q;
  logic                  row_en_q;
  logic                  frame_q;

  logic                  dwell_last;
  logic                  shift_start;
  logic                  shift_done;
  logic [3:0]            shift_row;
  logic [15:0]           row_word;

  assign dwell_last  = (dwell_q == DWELL_LAST);
  assign shift_start = (state_q == S_LOAD) ||
                       ((state_q == S_DISPLAY) && dwell_last && (row_q != 4'd15));
  // The shifter loads on the edge that enters SHIFT, so it needs the upcoming row.
  assign shift_row   = (state_q == S_LOAD) ? 4'd0 : row_q + 4'd1;

  always_comb begin
    row_word = '0;
    for (int c = 0; c < BOARD_COLS; c++) begin
      row_word[c] = snap_q[cell_idx(shift_row, 4'(c))];
    end
  end

  row_shift_out #(
    .SHIFT_DIV(SHIFT_DIV)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .start_i  (shift_start),
    .row_i    (row_word),
    .sr_data_o(sr_data_o),
    .sr_clk_o (sr_clk_o),
    .done_o   (shift_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      row_q     <= '0;
      dwell_q   <= '0;
      lat_q     <= '0;
      latch_q   <= 1'b0;
      row_sel_q <= '0;
      row_en_q  <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (en_i) begin
            state_q <= S_LOAD;
            snap_q  <= board_i;
            row_q   <= '0;
            frame_q <= 1'b1;
          end
        end
        S_LOAD: state_q <= S_SHIFT;
        S_SHIFT: begin
          if (shift_done) begin
            state_q  <= S_BLANK;
            row_en_q <= 1'b0;
          end
        end
        S_BLANK: begin
          state_q   <= S_LATCH;
          latch_q   <= 1'b1;
          row_sel_q <= row_q;
          lat_q     <= '0;
        end
        S_LATCH: begin
          if (lat_q == LAT_LAST) begin
            state_q  <= S_DISPLAY;
            latch_q  <= 1'b0;
            row_en_q <= 1'b1;
            dwell_q  <= '0;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_DISPLAY: begin
          if (dwell_last) begin
            if (row_q != 4'd15) begin
              row_q   <= row_q + 4'd1;
              state_q <= S_SHIFT;
            end else begin
              row_en_q <= 1'b0;
              // Enable is only honoured here, at the frame boundary.
              if (en_i) begin
                state_q <= S_LOAD;
                snap_q  <= board_i;
                row_q   <= '0;
                frame_q <= 1'b1;
              end else begin
                state_q   <= S_IDLE;
                row_sel_q <= '0;
              end
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sr_latch_o  = latch_q;
  assign row_sel_o   = row_sel_q;
  assign row_en_o    = row_en_q;
  assign frame_o     = frame_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_board_matrix_scanner.sv
// Self-checking bench: timing-level reference model with a row-word scoreboard
// for a fast-scan instance, plus a frame/shift timing check of a default instance.
module tb_board_matrix_scanner;
  import board_pkg::*;

  localparam int SD      = 1;
  localparam int DW      = 4;
  localparam int ROW_P   = 32 * SD + 1 + SD + DW;
  localparam int FRAME_P = 1 + 16 * ROW_P;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, en;
  logic [255:0] board;
  logic         sr_data, sr_clk, sr_latch, row_en, frame;
  logic [3:0]   row_sel;
  logic [5:0]   dbg_state;

  logic         reset_d, en_d;
  logic [255:0] board_d;
  logic         sr_data_d, sr_clk_d, sr_latch_d, row_en_d, frame_d;
  logic [3:0]   row_sel_d;
  logic [5:0]   dbg_state_d;

  board_matrix_scanner #(.SHIFT_DIV(SD), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .en_i(en), .board_i(board),
    .sr_data_o(sr_data), .sr_clk_o(sr_clk), .sr_latch_o(sr_latch),
    .row_sel_o(row_sel), .row_en_o(row_en), .frame_o(frame), .dbg_state_o(dbg_state)
  );

  board_matrix_scanner dut_d (
    .clk(clk), .reset(reset_d), .en_i(en_d), .board_i(board_d),
    .sr_data_o(sr_data_d), .sr_clk_o(sr_clk_d), .sr_latch_o(sr_latch_d),
    .row_sel_o(row_sel_d), .row_en_o(row_en_d), .frame_o(frame_d), .dbg_state_o(dbg_state_d)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic [255:0] rand_board();
    logic [255:0] b;
    logic [31:0]  w;
    int           mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < 8; i++) begin
      w = $urandom();
      if (mode == 1) w = w & $urandom();
      else if (mode == 2) w = w | $urandom();
      b[32*i +: 32] = w;
    end
    return b;
  endfunction

  function automatic logic [15:0] row_of(input logic [255:0] b, input int r);
    logic [15:0] w;
    for (int c = 0; c < 16; c++) w[c] = b[16*r + c];
    return w;
  endfunction

  // Reference model: position inside the frame, counted in clk cycles.
  logic [19:0]  exp_q[$];
  bit           m_valid  = 1'b0;
  bit           m_active = 1'b0;
  int           m_t      = 0;
  logic [255:0] m_snap   = '0;
  logic [3:0]   m_sel    = '0;

  task automatic start_frame();
    m_active = 1'b1;
    m_t      = 0;
    m_snap   = board;
    for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), row_of(board, r)});
  endtask

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (!reset) begin
      m_active = 1'b0;
      m_t      = 0;
      m_sel    = '0;
      exp_q.delete();
    end else if (!m_active) begin
      if (en) start_frame();
    end else if (m_t == FRAME_P - 1) begin
      if (en) start_frame();
      else begin
        m_active = 1'b0;
        m_sel    = '0;
      end
    end else begin
      m_t++;
      if (((m_t - 1) % ROW_P) == 32 * SD + 1) m_sel = 4'((m_t - 1) / ROW_P);
    end
  end

  // Cycle-level output check against the model.
  always @(negedge clk) begin
    logic e_frame, e_latch, e_row_en, e_clk, e_data;
    bit   chk_data;
    int   r, o;
    if (m_valid) begin
      e_frame = 1'b0; e_latch = 1'b0; e_row_en = 1'b0; e_clk = 1'b0; e_data = 1'b0;
      chk_data = 1'b0;
      if (m_active) begin
        if (m_t == 0) e_frame = 1'b1;
        else begin
          r = (m_t - 1) / ROW_P;
          o = (m_t - 1) % ROW_P;
          if (o < 32 * SD) begin
            e_clk    = ((o % (2 * SD)) >= SD);
            e_data   = m_snap[16*r + 15 - o / (2 * SD)];
            chk_data = 1'b1;
          end
          e_latch  = (o >= 32 * SD + 1) && (o < 33 * SD + 1);
          e_row_en = (o >= 33 * SD + 1) || ((o < 32 * SD) && (r > 0));
        end
      end else begin
        chk_data = 1'b1;
      end
      check("frame_o", frame, e_frame);
      check("sr_latch_o", sr_latch, e_latch);
      check("row_en_o", row_en, e_row_en);
      check("sr_clk_o", sr_clk, e_clk);
      check("row_sel_o", row_sel, m_sel);
      check("state_is_idle", dbg_state == ST_IDLE, !m_active);
      if (chk_data) check("sr_data_o", sr_data, e_data);
    end
  end

  // Scoreboard monitor: rebuilds the column register contents at each latch.
  logic        prev_clk = 1'b0, prev_latch = 1'b0;
  logic [15:0] cap_w = '0;
  int          cap_n = 0;
  logic [15:0] last_words[16];
  logic [19:0] exp_e;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      cap_n = 0;
      cap_w = '0;
    end else begin
      if (sr_clk && !prev_clk) begin
        cap_w = {cap_w[14:0], sr_data};
        cap_n++;
      end
      if (sr_latch && !prev_latch) begin
        if (exp_q.size() == 0) timeout_fail("latch_without_expected_row");
        else begin
          exp_e = exp_q.pop_front();
          check("row_word", cap_w, exp_e[15:0]);
          check("row_sel_at_latch", row_sel, exp_e[19:16]);
          check("bits_per_row", cap_n, 16);
        end
        last_words[row_sel] = cap_w;
        cap_n = 0;
      end
    end
    prev_clk   = sr_clk;
    prev_latch = sr_latch;
  end

  task automatic wait_t(input int t);
    int guard;
    guard = 0;
    while (!(m_active && m_t == t) && guard < 4 * FRAME_P) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4 * FRAME_P) timeout_fail($sformatf("wait_frame_cycle_%0d", t));
  endtask

  // Default-parameter instance: frame period and shift clock shape.
  int cyc_d = 0;
  bit def_run = 1'b0, def_done = 1'b0;
  logic d_prev_clk = 1'b0, d_prev_latch = 1'b0, d_prev_data = 1'b0;
  int hi_len = 0, rises = 0, last_rise = 0;

  always @(posedge clk) cyc_d++;

  always @(negedge clk) begin
    if (def_run) begin
      if (sr_clk_d) hi_len++;
      else if (d_prev_clk) begin
        check("def_clk_high_len", hi_len, 4);
        hi_len = 0;
      end
      if (sr_clk_d && !d_prev_clk) begin
        if (rises > 0) check("def_rise_spacing", cyc_d - last_rise, 8);
        last_rise = cyc_d;
        rises++;
      end
      if (sr_latch_d && !d_prev_latch) begin
        check("def_rises_per_row", rises, 16);
        rises = 0;
      end
      if (sr_data_d != d_prev_data) check("def_data_moves_with_clk_low", sr_clk_d, 0);
    end
    d_prev_clk   = sr_clk_d;
    d_prev_latch = sr_latch_d;
    d_prev_data  = sr_data_d;
  end

  initial begin
    int n, t1, g;
    reset_d = 1'b0;
    en_d    = 1'b1;
    board_d = rand_board();
    repeat (3) @(negedge clk);
    reset_d = 1'b1;
    g = 0;
    while (!frame_d && g < 10) begin @(negedge clk); g++; end
    if (!frame_d) timeout_fail("def_first_frame");
    t1 = cyc_d;
    def_run = 1'b1;
    n = 0;
    while (!sr_clk_d && n < 20) begin @(negedge clk); n++; end
    check("def_first_rise_after_frame", n, 5);
    g = 0;
    while (!frame_d && g < 20000) begin @(negedge clk); g++; end
    if (!frame_d) timeout_fail("def_second_frame");
    else begin
      check("def_frame_period", cyc_d - t1, 18513);
      check("def_state_load", dbg_state_d, ST_LOAD);
      check("def_row_en_at_load", row_en_d, 0);
      check("def_row_sel_held", row_sel_d, 15);
    end
    def_run  = 1'b0;
    def_done = 1'b1;
  end

  // Main directed + random sequence for the fast-scan instance.
  localparam logic [15:0] GLIDER_ROWS[3] = '{16'h0002, 16'h0004, 16'h0007};
  logic [255:0] glider;
  logic [15:0]  exp_w;

  initial begin
    int g;
    glider = '0;
    glider[1] = 1'b1; glider[18] = 1'b1;
    glider[32] = 1'b1; glider[33] = 1'b1; glider[34] = 1'b1;

    reset = 1'b0;
    en    = 1'b1;
    board = '1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    // Raised mid-cycle: IDLE takes en on the next edge, frame_o fills the cycle after.
    @(negedge clk);
    check("frame_after_reset", frame, 1);

    // Frame 1: all ones; board switches to the glider mid-frame.
    wait_t(1 + 7 * ROW_P + 5);
    board = glider;
    wait_t(FRAME_P - 1);
    // Frame 2: glider.
    wait_t(5);
    wait_t(FRAME_P - 1);
    for (int r = 0; r < 16; r++) begin
      exp_w = (r < 3) ? GLIDER_ROWS[r] : 16'h0000;
      check($sformatf("glider_row%0d", r), last_words[r], exp_w);
    end
    board = '0;
    // Frame 3: zeros, board goes all ones during row 7.
    wait_t(1 + 7 * ROW_P + 5);
    board = '1;
    wait_t(FRAME_P - 1);
    for (int r = 0; r < 16; r++) check($sformatf("tear_free_row%0d", r), last_words[r], 16'h0000);
    // Frame 4: all ones; enable dropped during row 3.
    wait_t(1 + 3 * ROW_P + 10);
    en = 1'b0;
    wait_t(FRAME_P - 1);
    for (int r = 0; r < 16; r++) check($sformatf("ones_row%0d", r), last_words[r], 16'hFFFF);
    repeat (60) @(negedge clk);
    check("idle_state", dbg_state, ST_IDLE);
    check("idle_row_en", row_en, 0);

    // Random boards, one mid-frame change, then reset at bit 9 of row 5.
    board = rand_board();
    en    = 1'b1;
    wait_t($urandom_range(1, FRAME_P - 2));
    board = rand_board();
    wait_t(FRAME_P - 1);
    board = rand_board();
    wait_t(1 + 5 * ROW_P + 9 * 2 * SD);
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_shift_clk", sr_clk, 0);
    check("reset_mid_shift_state", dbg_state, ST_IDLE);
    @(negedge clk);
    board = rand_board();
    reset = 1'b1;
    wait_t($urandom_range(1, FRAME_P - 2));
    en = 1'b0;
    wait_t(FRAME_P - 1);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    g = 0;
    while (!def_done && g < 25000) begin @(negedge clk); g++; end
    if (!def_done) timeout_fail("default_instance_checks");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_matrix_scanner.md
# board_matrix_scanner

Display-side reader of the 256-bit Game of Life board. It takes a tear-free snapshot of the board once per frame. Each 16-cell row is shifted out serially to external column shift registers (74HC595-style), latched, and then lit through a 4-bit row select. It sits downstream of the game top-level's board output and drives the 16x16 LED matrix pins directly.

## Interface
- `SHIFT_DIV`, default 4: half-period of `sr_clk_o` in `clk` cycles; legal range ≥1.
- `DWELL_CYCLES`, default 1024: cycles each row is lit; legal range ≥1.
- `clk`  input  1  system clock, the only clock in the block.
- `reset`  input  1  one clock; reset is synchronous and active-low.
- `en_i`  input  1  scan enable; sampled only at frame boundaries.
- `board_i`  input  256  board; bit `16*r+c` is the cell at row r, column c; 1 = alive.
- `sr_data_o`  output  1  serial column data.
- `sr_clk_o`  output  1  shift clock to the column registers; they capture on its rising edge.
- `sr_latch_o`  output  1  storage-register latch strobe, active high.
- `row_sel_o`  output  4  index of the row being driven.
- `row_en_o`  output  1  row driver enable, active high.
- `frame_o`  output  1  one-cycle pulse when a new snapshot is taken.

## Operation
- **Reset values:** while `reset`=0 at a rising edge, all outputs go to 0 and the FSM goes to IDLE. Reset mid-frame abandons the frame immediately. No partial latch strobe is allowed after reset.
- **States:** IDLE, LOAD, SHIFT, BLANK, LATCH, DISPLAY.
- **IDLE:** all outputs 0. Move to LOAD when `en_i`=1.
- **LOAD:** lasts 1 cycle.
  - Copy `board_i` into the internal 256-bit snapshot.
  - Set `frame_o`=1 and row counter=0.
  - Go to SHIFT.
- **SHIFT:** sends the 16 bits of the current snapshot row, column 15 first and column 0 last. After 16 clocks, column c sits on shift-register output Qc.
  - Each bit lasts 2*`SHIFT_DIV` cycles.
  - `sr_data_o` is stable for the whole bit.
  - `sr_clk_o` is low for the first `SHIFT_DIV` cycles and high for the second.
  - After bit 16, `sr_clk_o` returns to 0 and the FSM goes to BLANK.
- **BLANK:** lasts 1 cycle. `row_en_o`=0, then go to LATCH.
- **LATCH:** lasts `SHIFT_DIV` cycles.
  - `sr_latch_o`=1 throughout.
  - `row_sel_o` takes the current row index on entry.
- **DISPLAY:** lasts `DWELL_CYCLES` cycles with `row_en_o`=1. At the end of the last cycle:
  - If row < 15: increment the row and go to SHIFT. `row_en_o` stays 1 during the next row's SHIFT. The matrix keeps showing the previously latched row until BLANK.
  - If row = 15: `row_en_o`→0. Then go to LOAD if `en_i`=1, otherwise IDLE.
- **Snapshot rule:**
  - Changes on `board_i` mid-frame are invisible until the next LOAD.
  - `en_i` deasserted mid-frame takes effect only at the end of row 15.
- **Counter widths:**
  - Bit counter: 4 bits.
  - Row counter: 4 bits, wrapping 15→0 only through LOAD.
  - Divider counter: $clog2(`SHIFT_DIV`)+1 bits.
  - Dwell counter: $clog2(`DWELL_CYCLES`)+1 bits.

## Timing
- Row period = 32*`SHIFT_DIV` + 1 + `SHIFT_DIV` + `DWELL_CYCLES`. With defaults: 128+1+4+1024 = 1157 cycles.
- Frame period = 1 + 16*row period. With defaults: 18513 cycles between `frame_o` pulses.
- First `sr_clk_o` rising edge occurs `SHIFT_DIV`+1 cycles after `frame_o` is high.
- `sr_data_o` changes only on `clk` edges where `sr_clk_o` is low, giving ≥`SHIFT_DIV` cycles of setup and hold around each rising edge.
- `sr_latch_o` never overlaps `sr_clk_o`=1.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `board_pkg`:
  - `BOARD_ROWS`=16, `BOARD_COLS`=16, `BOARD_BITS`=256.
  - Scanner state localparams: one-hot, 6 bits.
  - Cell index function `16*r+c`.
- One sub-module, `row_shift_out`:
  - Inputs: 16-bit parallel row, start pulse.
  - Outputs: `sr_data_o`, `sr_clk_o`, done pulse.
  - Owns the divider and bit counter.
- The top scanner owns the snapshot, row counter, dwell counter and FSM.

## Test plan
All scenarios use `SHIFT_DIV`=1 and `DWELL_CYCLES`=4 unless stated, giving a row period of 38 and a frame period of 609.

- **Reset hold:** `reset`=0 for 5 cycles with `en_i`=1 and `board_i`=all ones → every output 0 throughout. The first `frame_o` appears 2 cycles after `reset` rises.
- **Single glider:**
  - Stimulus: `board_i` with bits 1, 18, 32, 33, 34 set.
  - Capture 16 bits per `sr_clk_o` rising edge, then `sr_latch_o`.
  - Required words: row0=0x0002, row1=0x0004, row2=0x0007, rows 3–15 = 0x0000.
  - `row_sel_o` must step 0..15.
- **Tear-free snapshot:** change `board_i` from all zeros to all ones during row 7 → rows 7–15 still shift 0x0000. The next frame shifts 0xFFFF on every row.
- **Enable mid-frame:** drop `en_i` during row 3 → the frame completes through row 15. FSM enters IDLE, `row_en_o`=0, and no further `frame_o` occurs.
- **Reset mid-shift:** assert `reset`=0 at bit 9 of row 5 → next cycle all outputs are 0. No `sr_latch_o` pulse appears for the abandoned row.
- **Default timing:** `SHIFT_DIV`=4, `DWELL_CYCLES`=1024 → `frame_o` pulses are exactly 18513 cycles apart. `sr_clk_o` is high for 4 cycles and low for 4 cycles.
